b14_mem: RTL and testbench

B14_MEM -- requirements
Module: b14_mem

---
 rtl/b14_mem_pkg.sv | 13 +
 rtl/b14_mem_ram.sv | 26 ++
 rtl/b14_mem.sv | 98 +++++++++
 tb/tb_b14_mem.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/b14_mem_pkg.sv
// Shared types and widths for the b14 boot-loaded memory.
package b14_mem_pkg;

  localparam int DW_DEFAULT = 31;
  localparam int CORE_AW    = 20;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/b14_mem_ram.sv
// Single-write-port, read-first synchronous RAM with a registered, clearable read port.
module b14_mem_ram #(
  parameter int AW = 8,
  parameter int DW = 31
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Read samples the pre-write word, so a same-address read/write returns old data.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (rclr) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/b14_mem.sv
// Boot memory: loader fills the array while the core is held in reset, then the core runs on it.
module b14_mem
  import b14_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = DW_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ld_valid,
  input  logic [DW-1:0]      ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  input  logic [CORE_AW-1:0] core_addr,
  input  logic               core_rd,
  input  logic               core_wr,
  input  logic [DW-1:0]      core_datao,
  output logic [DW-1:0]      core_datai,
  output logic               core_reset,
  output logic               running,
  output logic               oob_err,
  output logic [15:0]        wr_count
);

  state_t        state;
  logic [AW-1:0] ld_ptr;
  logic          in_range;
  logic          ld_xfer;
  logic          core_wr_ok;
  logic          core_oob;
  logic          ram_we;
  logic          ram_rclr;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  always_comb begin
    in_range   = (core_addr[CORE_AW-1:AW] == '0);
    ld_xfer    = (state == LOAD) && ld_valid && ld_ready;
    core_wr_ok = (state == RUN) && core_wr && in_range;
    core_oob   = (state == RUN) && (core_rd || core_wr) && !in_range;
    // Reset wins over any same-cycle transfer; the array itself is never cleared.
    ram_we     = !reset && (ld_xfer || core_wr_ok);
    ram_rclr   = reset || (state != RUN) || !in_range;
    ram_waddr  = (state == LOAD) ? ld_ptr  : core_addr[AW-1:0];
    ram_wdata  = (state == LOAD) ? ld_data : core_datao;
  end

  b14_mem_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .rclr  (ram_rclr),
    .raddr (core_addr[AW-1:0]),
    .rdata (core_datai)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD;
      ld_ptr     <= '0;
      ld_ready   <= 1'b1;
      core_reset <= 1'b1;
      running    <= 1'b0;
      oob_err    <= 1'b0;
      wr_count   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_xfer) begin
            // Pointer parks at the top word instead of wrapping.
            if (ld_ptr != '1) ld_ptr <= ld_ptr + AW'(1);
            if (ld_last || (ld_ptr == '1)) begin
              state    <= RELEASE;
              ld_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          state      <= RUN;
          core_reset <= 1'b0;
          running    <= 1'b1;
        end
        RUN: begin
          if (core_oob) oob_err <= 1'b1;
          if (core_wr_ok && (wr_count != '1)) wr_count <= wr_count + 16'd1;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b14_mem.sv
// Randomized scoreboard bench for b14_mem against an array-based reference model.
module tb_b14_mem;

  localparam int AW    = 8;
  localparam int DW    = 31;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic [19:0]   core_addr = '0;
  logic          core_rd = 1'b0;
  logic          core_wr = 1'b0;
  logic [DW-1:0] core_datao = '0;
  logic [DW-1:0] core_datai;
  logic          core_reset;
  logic          running;
  logic          oob_err;
  logic [15:0]   wr_count;

  b14_mem #(.AW(AW), .DW(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .core_addr  (core_addr),
    .core_rd    (core_rd),
    .core_wr    (core_wr),
    .core_datao (core_datao),
    .core_datai (core_datai),
    .core_reset (core_reset),
    .running    (running),
    .oob_err    (oob_err),
    .wr_count   (wr_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: memory image, which words hold defined data, write counter, sticky error.
  logic [DW-1:0] mdl [DEPTH];
  bit            known [DEPTH];
  int unsigned   mcount = 0;
  bit            moob = 1'b0;

  typedef struct {
    bit            care;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sbq[$];
  logic issue = 1'b0;
  logic issued_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one registered read result is due the cycle after each issued core op.
  always @(posedge clock) issued_d <= issue;

  always @(negedge clock) begin
    exp_t e;
    if (issued_d) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got %0h expected queued entry", core_datai);
      end else begin
        e = sbq.pop_front();
        if (e.care) chk("rd_data", 32'(core_datai), 32'(e.val));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ld_word(input logic [DW-1:0] d, input bit last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic core_op(input logic [19:0] a, input bit rd, input bit wr, input logic [DW-1:0] d);
    exp_t          e;
    bit            inr;
    logic [AW-1:0] idx;
    inr = ((a >> AW) == 0);
    idx = a[AW-1:0];
    core_addr  = a;
    core_rd    = rd;
    core_wr    = wr;
    core_datao = d;
    issue      = 1'b1;
    if (inr) begin
      e.care = known[idx];
      e.val  = mdl[idx];
    end else begin
      e.care = 1'b1;
      e.val  = '0;
    end
    sbq.push_back(e);
    if (wr && inr) begin
      mdl[idx]   = d;
      known[idx] = 1'b1;
      if (mcount < 65535) mcount++;
    end
    if ((rd || wr) && !inr) moob = 1'b1;
    tick();
    core_rd = 1'b0;
    core_wr = 1'b0;
    issue   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ld_ready"},   32'(ld_ready),   32'd1);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_running"},    32'(running),    32'd0);
    chk({tag, "_oob_err"},    32'(oob_err),    32'd0);
    chk({tag, "_wr_count"},   32'(wr_count),   32'd0);
    chk({tag, "_core_datai"}, 32'(core_datai), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    mcount = 0;
    moob   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0]   a;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    tick();
    do_reset();
    chk_reset_state("rst0");

    // Three-word boot image.
    ld_word(DW'(1), 1'b0); mdl[0] = 1; known[0] = 1'b1;
    chk("ld1_ready", 32'(ld_ready), 32'd1);
    ld_word(DW'(2), 1'b0); mdl[1] = 2; known[1] = 1'b1;
    ld_word(DW'(3), 1'b1); mdl[2] = 3; known[2] = 1'b1;
    chk("rel_ld_ready",   32'(ld_ready),   32'd0);
    chk("rel_core_reset", 32'(core_reset), 32'd1);
    chk("rel_running",    32'(running),    32'd0);
    tick();
    chk("run_core_reset", 32'(core_reset), 32'd0);
    chk("run_running",    32'(running),    32'd1);
    chk("run_ld_ready",   32'(ld_ready),   32'd0);
    chk("run_datai0",     32'(core_datai), 32'd0);

    core_op(20'd2, 1'b1, 1'b0, '0);
    core_op(20'd0, 1'b1, 1'b0, '0);
    core_op(20'd5, 1'b0, 1'b1, 31'h7FFFFFFF);
    core_op(20'd5, 1'b1, 1'b0, '0);
    chk("wr_count_1", 32'(wr_count), 32'd1);
    core_op(20'd5, 1'b1, 1'b1, 31'h1234);
    core_op(20'd5, 1'b1, 1'b0, '0);
    core_op(20'h00100, 1'b0, 1'b1, 31'h55);
    chk("oob_set",      32'(oob_err),  32'd1);
    chk("oob_wr_count", 32'(wr_count), 32'(mcount));
    core_op(20'd0, 1'b1, 1'b0, '0);
    core_op(20'd1, 1'b1, 1'b0, '0);

    // Random core traffic, including out-of-range strobes and idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = 20'($urandom);
        if ((a >> AW) == 0) a[AW] = 1'b1;
      end else begin
        a = 20'($urandom_range(0, DEPTH - 1));
      end
      core_op(a, 1'($urandom), 1'($urandom), DW'($urandom));
      if ($urandom_range(0, 7) == 0) tick();
    end
    chk("rand_wr_count", 32'(wr_count), 32'(mcount));
    chk("rand_oob",      32'(oob_err),  32'(moob));

    // Reset mid-RUN with loader active, then partial load and reset mid-LOAD.
    ld_valid = 1'b1;
    ld_data  = DW'(32'h1BAD_BEEF);
    do_reset();
    ld_valid = 1'b0;
    chk_reset_state("rst1");
    ld_word(DW'(32'h0ABC), 1'b0); mdl[0] = 32'h0ABC; known[0] = 1'b1;
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = DW'(32'h2DEA_D000);
    tick();
    reset    = 1'b0;
    ld_valid = 1'b0;
    chk_reset_state("rst2");
    ld_word(DW'(32'h2AAA), 1'b1); mdl[0] = 32'h2AAA; known[0] = 1'b1;
    tick();
    chk("reload_running", 32'(running), 32'd1);
    core_op(20'd0, 1'b1, 1'b0, '0);
    core_op(20'd1, 1'b1, 1'b0, '0);
    core_op(20'd2, 1'b1, 1'b0, '0);
    core_op(20'd5, 1'b1, 1'b0, '0);

    // Full-depth load without ld_last, with valid gaps; loader held active afterwards.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        ld_data = DW'($urandom);
        tick();
      end
      d = DW'($urandom);
      ld_word(d, 1'b0);
      mdl[i]   = d;
      known[i] = 1'b1;
      if (i < DEPTH - 1) chk("full_ld_ready", 32'(ld_ready), 32'd1);
    end
    chk("full_rel_ready", 32'(ld_ready),   32'd0);
    chk("full_rel_creset", 32'(core_reset), 32'd1);
    ld_valid = 1'b1;
    ld_data  = DW'(32'h3FFF_0000);
    tick();
    tick();
    ld_valid = 1'b0;
    chk("full_running", 32'(running), 32'd1);
    for (int i = 0; i < DEPTH; i++) core_op(20'(i), 1'b1, 1'b0, '0);
    chk("full_wr_count", 32'(wr_count), 32'd0);

    tick();
    tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
